seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 Parameter: NUM_DIGITS, default 8, digits scanned (fixed at 8 in this revision).
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: data_in  input  32  eight hex nibbles; nibble k drives digit k.
REQ-006 Port: dp_in  input  8  decimal point per digit, 1 = lit.
REQ-007 Port: digit_en  input  8  per-digit enable, 0 = anode held off in its slot.
REQ-008 Port: load  input  1  one-cycle strobe capturing data_in/dp_in into staging.
REQ-009 Port: load_ack  output  1  one-cycle pulse when staging commits to display.
REQ-010 Port: frame_done  output  1  one-cycle pulse when digit index wraps from 7 to 0.
REQ-011 Port: an  output  8  anodes, active-low, one-hot-low while scanning.
REQ-012 Port: seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-013 Port: dp  output  1  decimal point cathode, active-low.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 and SHALL assert internal tick in the cycle it equals REFRESH_DIV-1, then wrap to 0.
REQ-015 FSM states BLANK and SCAN; BLANK entered on reset, exits to SCAN with digit index 0 on the first tick.
REQ-016 In SCAN, each tick SHALL advance digit index modulo 8; index 7 -> 0 is the frame boundary.
REQ-017 an/seg/dp SHALL be registered, reflecting index and display register one cycle after they change.
REQ-018 In BLANK, an = 8'hFF, seg = 7'h7F, dp = 1.
REQ-019 In SCAN, an bit index SHALL be 0 only if digit_en[index] = 1; otherwise an = 8'hFF for that slot.
REQ-020 Hex decode: 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E; full 16-entry table in package.
REQ-021 load SHALL capture data_in/dp_in into staging on the same edge and set pending.
REQ-022 At frame boundary with pending set, staging SHALL copy to display, pending clear, load_ack and frame_done pulse together.
REQ-023 load coincident with commit: display receives old staging, staging receives new data, pending stays set, load_ack pulses.
REQ-024 Multiple loads within one frame: last one wins; exactly one load_ack at the next boundary.
REQ-025 Display register SHALL change only at a frame boundary, never mid-frame.

Reset
REQ-026 rst SHALL clear prescaler, index, pending, staging, display to 0 and enter BLANK.
REQ-027 Reset values: an = 8'hFF, seg = 7'h7F, dp = 1, load_ack = 0, frame_done = 0.
REQ-028 rst mid-frame SHALL discard pending data without asserting load_ack; rst dominates load.

Configuration
REQ-029 Macro SEG_SCAN_BLANK_EN defined: digits above the highest nonzero display nibble SHALL show seg = 7'h7F (dp still honoured); digit 0 never blanked.
REQ-030 SEG_SCAN_BLANK_EN undefined: every enabled digit SHALL show its decoded nibble, leading zeros included.

Structure
REQ-031 Package seg_pkg SHALL hold the 16-entry hex-to-segment table, SEG_BLANK = 7'h7F, NUM_DIGITS = 8 and the FSM state typedef.
REQ-032 Sub-module hex7seg (combinational nibble -> segments) SHALL be instantiated once on the selected nibble.

Verification (REFRESH_DIV = 4)
REQ-033 Reset then run 40 cycles -> an = FF until first tick, then FE, FD, FB ... 7F, FE; frame_done every 32 cycles.
REQ-034 load with data_in = 32'h0000_0001 mid-frame -> display unchanged until boundary; load_ack and frame_done together; digit 0 seg = 7'h79.
REQ-035 load on the exact boundary cycle -> load_ack pulses, old staging shown, new value shown one frame later with a second load_ack.
REQ-036 digit_en = 8'h0F -> an = FF during slots 4..7, normal in slots 0..3.
REQ-037 SEG_SCAN_BLANK_EN defined, display = 32'h0000_00A0 -> digits 2..7 seg = 7'h7F, digit 0 shows 7'h40; undefined -> digits 2..7 show 7'h40.
REQ-038 rst asserted with pending load -> no load_ack, outputs at reset values next cycle, display = 0 after restart.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned SEG_W      = 7;

   // All cathodes off (active-low).
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   // Hex nibble -> {g,f,e,d,c,b,a}, active-low; entry 15 first.
   localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SCAN  = 1'b1
   } state_t;

   // One full frame of digit data plus decimal points.
   typedef struct packed {
      logic [NUM_DIGITS*NIB_W-1:0] data;
      logic [NUM_DIGITS-1:0]       dp;
   } frame_t;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
   import seg_pkg::*;
(
   input  logic [NIB_W-1:0] nib_i,
   output logic [SEG_W-1:0] seg_o_c
);

   // Table lookup into the shared decode ROM.
   assign seg_o_c = HEX_TABLE[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller with frame-synchronous
// double-buffered display update.
// Optional build macro: SEG_SCAN_BLANK_EN -- blank leading zero digits
// (digit 0 is never blanked, decimal points are still shown).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned NUM_DIGITS  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NIB_W*NUM_DIGITS-1:0]   data_in,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   input  logic                          load,
   output logic                          load_ack,
   output logic                          frame_done,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [SEG_W-1:0]              seg,
   output logic                          dp
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   frame_t                stg_q, stg_d;
   frame_t                disp_q, disp_d;
   logic                  pend_q, pend_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic                  load_ack_q;
   logic                  frame_done_q;

   logic                  tick_c;
   logic                  boundary_c;
   logic                  commit_c;
   logic                  lead_blank_c;
   logic [NIB_W-1:0]      nib_c;
   logic [SEG_W-1:0]      seg_dec_c;

   // Prescaler: one tick per digit slot.
   assign tick_c = (cnt_q == CNT_MAX);
   assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);

   // Frame boundary is the tick that wraps the digit index back to 0.
   assign boundary_c = tick_c && (state_q == ST_SCAN) && (idx_q == IDX_MAX);
   assign commit_c   = boundary_c && pend_q;

   // Next-state logic for the scan FSM and digit index.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (tick_c) begin
         case (state_q)
            ST_BLANK: begin
               state_d = ST_SCAN;
               idx_d   = '0;
            end
            ST_SCAN: begin
               idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            end
            default: begin
               state_d = ST_BLANK;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Staging/display double buffer; commit reads old staging before a new load lands.
   always_comb begin
      stg_d  = stg_q;
      disp_d = disp_q;
      pend_d = pend_q;
      if (commit_c) begin
         disp_d = stg_q;
         pend_d = 1'b0;
      end
      if (load) begin
         stg_d.data = data_in;
         stg_d.dp   = dp_in;
         pend_d     = 1'b1;
      end
   end

   // Nibble for the digit currently being driven.
   assign nib_c = disp_q.data[NIB_W*idx_q +: NIB_W];

   hex7seg u_hex7seg (
      .nib_i   (nib_c),
      .seg_o_c (seg_dec_c)
   );

`ifdef SEG_SCAN_BLANK_EN
   logic [IDX_W-1:0] hi_idx_c;

   // Highest digit holding a nonzero nibble (0 when the display is all zeros).
   always_comb begin
      hi_idx_c = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (disp_q.data[NIB_W*k +: NIB_W] != '0) begin
            hi_idx_c = IDX_W'(k);
         end
      end
   end

   assign lead_blank_c = (idx_q > hi_idx_c);
`else
   assign lead_blank_c = 1'b0;
`endif

   // Output drive computed from the current index and display contents.
   always_comb begin
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_q == ST_SCAN) begin
         if (digit_en[idx_q]) begin
            an_d[idx_q] = 1'b0;
         end
         seg_d = lead_blank_c ? SEG_BLANK : seg_dec_c;
         dp_d  = ~disp_q.dp[idx_q];
      end
   end

   // All state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         state_q      <= ST_BLANK;
         idx_q        <= '0;
         stg_q        <= '0;
         disp_q       <= '0;
         pend_q       <= 1'b0;
         an_q         <= '1;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         load_ack_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         idx_q        <= idx_d;
         stg_q        <= stg_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         load_ack_q   <= commit_c;
         frame_done_q <= boundary_c;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign load_ack   = load_ack_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with REFRESH_DIV = 4.
// Honours SEG_SCAN_BLANK_EN the same way the design does.
module tb_seg_scan_ctrl;

   localparam int DIV = 4;

`ifdef SEG_SCAN_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  digit_en;
   logic        load;
   logic        load_ack;
   logic        frame_done;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;

   seg_scan_ctrl #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .load_ack   (load_ack),
      .frame_done (frame_done),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int n_total = 0;
   int n_pass  = 0;
   bit chk_on  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: n = clock edges since reset; slot count = n / DIV.
   int         n;
   logic [31:0] m_stg, m_disp;
   logic [7:0]  m_stg_dp, m_disp_dp;
   bit          m_pend;
   logic [7:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp, exp_ack, exp_fd;

   always @(posedge clk) begin
      int s, idx, hi;
      bit bnd;
      if (rst) begin
         n = 0; m_stg = '0; m_disp = '0; m_stg_dp = '0; m_disp_dp = '0; m_pend = 1'b0;
         exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ack = 1'b0; exp_fd = 1'b0;
      end else begin
         // outputs show the digit selected before this edge
         s = n / DIV;
         if (s == 0) begin
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
         end else begin
            idx = (s - 1) % 8;
            exp_an = 8'hFF;
            if (digit_en[idx]) exp_an[idx] = 1'b0;
            hi = 0;
            for (int k = 0; k < 8; k++) if (m_disp[4*k +: 4] != 4'h0) hi = k;
            exp_seg = (BLANK_EN && idx > hi) ? 7'h7F : hex_ref[m_disp[4*idx +: 4]];
            exp_dp  = ~m_disp_dp[idx];
         end
         n++;
         bnd = (n % DIV == 0) && (n / DIV > 1) && (((n / DIV) - 1) % 8 == 0);
         exp_fd  = bnd;
         exp_ack = bnd && m_pend;
         if (exp_ack) begin
            m_disp = m_stg; m_disp_dp = m_stg_dp; m_pend = 1'b0;
         end
         if (load) begin
            m_stg = data_in; m_stg_dp = dp_in; m_pend = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("an", 32'(an), 32'(exp_an));
         check("seg", 32'(seg), 32'(exp_seg));
         check("dp", 32'(dp), 32'(exp_dp));
         check("load_ack", 32'(load_ack), 32'(exp_ack));
         check("frame_done", 32'(frame_done), 32'(exp_fd));
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; digit_en = 8'hFF;
      step(3);
      chk_on = 1'b1;
      check("rst_an", 32'(an), 32'h0FF);
      check("rst_seg", 32'(seg), 32'h07F);
      rst = 1'b0;

      // Scan startup and frame timing
      step(4);  check("an_before_tick", 32'(an), 32'h0FF);
      step(1);  check("an_slot0", 32'(an), 32'h0FE);
      step(4);  check("an_slot1", 32'(an), 32'h0FD);
      step(27); check("fd_first", 32'(frame_done), 32'h1);
                check("an_slot7", 32'(an), 32'h07F);
      step(1);  check("an_wrap", 32'(an), 32'h0FE);
                check("fd_low", 32'(frame_done), 32'h0);

      // Mid-frame load commits only at the boundary
      data_in = 32'h0000_0001; load = 1'b1;
      step(1);  load = 1'b0; data_in = $urandom;
      step(29); check("no_early_ack", 32'(load_ack), 32'h0);
      step(1);  check("ack_at_bnd", 32'(load_ack), 32'h1);
                check("fd_with_ack", 32'(frame_done), 32'h1);
      step(1);  check("digit0_one", 32'(seg), 32'h079);

      // Load coincident with commit
      data_in = 32'h0000_0003; load = 1'b1;
      step(1);  load = 1'b0;
      step(29); data_in = 32'h0000_0005; load = 1'b1;
      step(1);  load = 1'b0;
                check("ack_coincident", 32'(load_ack), 32'h1);
      step(1);  check("old_staging_shown", 32'(seg), 32'h030);
      step(31); check("second_ack", 32'(load_ack), 32'h1);
      step(1);  check("new_value_shown", 32'(seg), 32'h012);

      // Partial digit enable
      digit_en = 8'h0F;
      step(13); check("en_slot3", 32'(an), 32'h0F7);
      step(4);  check("en_slot4_off", 32'(an), 32'h0FF);
      digit_en = 8'hFF;

      // Leading-zero handling
      data_in = 32'h0000_00A0; dp_in = 8'h00; load = 1'b1;
      step(1);  load = 1'b0;
      step(13); check("ack_A0", 32'(load_ack), 32'h1);
      step(1);  check("A0_digit0", 32'(seg), 32'h040);
      step(4);  check("A0_digit1", 32'(seg), 32'h008);
      step(4);  check("A0_digit2", 32'(seg), BLANK_EN ? 32'h07F : 32'h040);

      // Reset discards pending data and dominates load
      data_in = 32'h1234_5678; dp_in = 8'hA5; load = 1'b1;
      step(1);  load = 1'b0;
      step(5);  rst = 1'b1; load = 1'b1;
      step(1);  check("rst_mid_an", 32'(an), 32'h0FF);
                check("rst_mid_seg", 32'(seg), 32'h07F);
                check("rst_mid_dp", 32'(dp), 32'h1);
                check("rst_mid_ack", 32'(load_ack), 32'h0);
      rst = 1'b0; load = 1'b0;
      step(5);  check("restart_an", 32'(an), 32'h0FE);
                check("restart_seg", 32'(seg), 32'h040);
      step(31); check("restart_fd", 32'(frame_done), 32'h1);
                check("restart_no_ack", 32'(load_ack), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         data_in = $urandom;
         dp_in   = 8'($urandom);
         load    = ($urandom % 16) == 0;
         if (($urandom % 64) == 0) digit_en = 8'($urandom);
         rst     = ($urandom % 1200) == 0;
         step(1);
      end
      rst = 1'b0; load = 1'b0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
